sgpr_wr_arb: RTL and testbench

SGPR_WR_ARB -- requirements
Module: sgpr_wr_arb

---
 rtl/sgpr_wr_arb.sv | 136 +++++++++++++
 tb/tb_sgpr_wr_arb.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgpr_wr_arb.sv
// Round-robin arbiter funnelling scalar-register writes from several requesters
// onto one registered register-file write port, with strobe normalisation and NULL-SGPR filtering.
module sgpr_wr_arb #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned BANKS      = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*$clog2(BANKS)-1:0]    req_bank,
    input  logic [NUM_REQ*$clog2(DEPTH)-1:0]    req_addr,
    input  logic [NUM_REQ*2*DATA_WIDTH-1:0]     req_data,
    input  logic [NUM_REQ*2-1:0]                req_strb,
    input  logic                                hold,
    output logic [$clog2(BANKS)-1:0]            wr_bank_sel,
    output logic [$clog2(DEPTH)-1:0]            waddr,
    output logic [2*DATA_WIDTH-1:0]             wdata,
    output logic [1:0]                          wstrb,
    output logic                                wenable,
    output logic                                null_drop
);

    localparam int unsigned BW  = $clog2(BANKS);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned DW2 = 2 * DATA_WIDTH;
    localparam int unsigned PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // SGPR 125 is the NULL register; 124 is its even partner in a 64-bit pair
    localparam logic [AW-1:0] NULL_ADDR = AW'(125);
    localparam logic [AW-1:0] PAIR_ADDR = AW'(124);

    logic [PW-1:0]  rr_ptr;
    logic [PW-1:0]  rr_ptr_nxt;
    logic [PW-1:0]  grant_idx;
    logic [PW:0]    cand;
    logic           grant_vld;

    logic [BW-1:0]  sel_bank;
    logic [AW-1:0]  sel_addr;
    logic [DW2-1:0] sel_data;
    logic [1:0]     sel_strb;
    logic [DW2-1:0] data_n;
    logic [1:0]     strb_n;
    logic           is_null;
    logic           pair_null;
    logic           wr_nxt;
    logic           drop_nxt;

    // Rotating priority search starting at rr_ptr
    always_comb begin : arb
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (PW+1)'(rr_ptr) + (PW+1)'(i);
            if (cand >= (PW+1)'(NUM_REQ)) begin
                cand = cand - (PW+1)'(NUM_REQ);
            end
            if (!grant_vld && req_valid[cand[PW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[PW-1:0];
            end
        end
        if (reset || hold) begin
            grant_vld = 1'b0;
        end
        req_ready = '0;
        if (grant_vld) begin
            req_ready = NUM_REQ'(1) << grant_idx;
        end
    end

    always_comb begin : payload_mux
        sel_bank = '0;
        sel_addr = '0;
        sel_data = '0;
        sel_strb = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PW'(i)) begin
                sel_bank = req_bank[i*BW +: BW];
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW2 +: DW2];
                sel_strb = req_strb[i*2 +: 2];
            end
        end
    end

    // Odd addresses carry a single word in the low half; NULL writes are filtered out
    always_comb begin : normalise
        strb_n    = sel_strb;
        data_n    = sel_data;
        pair_null = 1'b0;
        if (sel_addr[0]) begin
            strb_n = {1'b0, sel_strb[0]};
            data_n = {DATA_WIDTH'(0), sel_data[DATA_WIDTH-1:0]};
        end
        is_null = (sel_addr == NULL_ADDR);
        if ((sel_addr == PAIR_ADDR) && strb_n[1]) begin
            strb_n[1] = 1'b0;
            pair_null = 1'b1;
        end
        wr_nxt     = grant_vld && !is_null && (strb_n != 2'b00);
        drop_nxt   = grant_vld && (is_null || pair_null);
        rr_ptr_nxt = rr_ptr;
        if (grant_vld) begin
            rr_ptr_nxt = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

    // Output stage; payload only moves on a real write so it holds otherwise
    always_ff @(posedge clk) begin : out_stage
        if (reset) begin
            rr_ptr      <= '0;
            wenable     <= 1'b0;
            null_drop   <= 1'b0;
            wr_bank_sel <= '0;
            waddr       <= '0;
            wdata       <= '0;
            wstrb       <= '0;
        end else begin
            rr_ptr    <= rr_ptr_nxt;
            wenable   <= wr_nxt;
            null_drop <= drop_nxt;
            if (wr_nxt) begin
                wr_bank_sel <= sel_bank;
                waddr       <= sel_addr;
                wdata       <= data_n;
                wstrb       <= strb_n;
            end
        end
    end

endmodule

// File: tb/tb_sgpr_wr_arb.sv
// Self-checking bench for sgpr_wr_arb: directed scenarios plus random traffic
// compared against a behavioural round-robin / write-filter model.
module tb_sgpr_wr_arb;

    localparam int N  = 3;
    localparam int BW = 4;
    localparam int AW = 7;

    logic               clk = 1'b0;
    logic               reset;
    logic               hold;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*BW-1:0]    req_bank;
    logic [N*AW-1:0]    req_addr;
    logic [N*64-1:0]    req_data;
    logic [N*2-1:0]     req_strb;
    logic [BW-1:0]      wr_bank_sel;
    logic [AW-1:0]      waddr;
    logic [63:0]        wdata;
    logic [1:0]         wstrb;
    logic               wenable;
    logic               null_drop;

    sgpr_wr_arb dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_bank   (req_bank),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_strb   (req_strb),
        .hold       (hold),
        .wr_bank_sel(wr_bank_sel),
        .waddr      (waddr),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wenable    (wenable),
        .null_drop  (null_drop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: pointer plus the expected write-port contents
    int          m_ptr  = 0;
    logic [3:0]  m_bank = '0;
    logic [6:0]  m_addr = '0;
    logic [63:0] m_data = '0;
    logic [1:0]  m_strb = '0;
    logic        m_we   = 1'b0;
    logic        m_nd   = 1'b0;

    int dut_wr_cnt = 0;
    int exp_wr_cnt = 0;
    int wait_cnt[N];
    int max_wait   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic [3:0] b,
                            input logic [6:0] a, input logic [63:0] d, input logic [1:0] s);
        req_valid = (req_valid & ~(3'(1) << p)) | (3'(v) << p);
        req_bank  = (req_bank & ~(12'hF << (p*BW))) | (12'(b) << (p*BW));
        req_addr  = (req_addr & ~(21'h7F << (p*AW))) | (21'(a) << (p*AW));
        req_data  = (req_data & ~(192'(64'hFFFF_FFFF_FFFF_FFFF) << (p*64))) | (192'(d) << (p*64));
        req_strb  = (req_strb & ~(6'h3 << (p*2))) | (6'(s) << (p*2));
    endtask

    // One clock: check grant before the edge, then the write port after it
    task automatic step();
        int          g;
        logic [N-1:0] exp_ready;
        logic [3:0]  b;
        logic [6:0]  a;
        logic [63:0] d;
        logic [1:0]  s;
        logic        we;
        logic        nd;
        #1;
        g = -1;
        if (!reset && !hold) begin
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_ptr + k) % N;
                if (g < 0 && 1'(req_valid >> p)) g = p;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready = 3'(1 << g);
        check_eq("req_ready", 64'(req_ready), 64'(exp_ready));

        for (int i = 0; i < N; i++) begin
            if (!1'(req_valid >> i) || 1'(req_ready >> i)) begin
                wait_cnt[i] = 0;
            end else if (req_ready != '0) begin
                wait_cnt[i]++;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
        end

        we = 1'b0;
        nd = 1'b0;
        b  = '0;
        a  = '0;
        d  = '0;
        s  = '0;
        if (g >= 0) begin
            b = 4'(req_bank >> (g*BW));
            a = 7'(req_addr >> (g*AW));
            d = 64'(req_data >> (g*64));
            s = 2'(req_strb >> (g*2));
            if (a % 2 == 1) begin
                s = {1'b0, s[0]};
                d = d & 64'h0000_0000_FFFF_FFFF;
            end
            if (a == 7'd125) begin
                nd = 1'b1;
            end else begin
                if (a == 7'd124 && s[1]) begin
                    s[1] = 1'b0;
                    nd   = 1'b1;
                end
                we = (s != 2'b00);
            end
            if (we) exp_wr_cnt++;
        end

        @(posedge clk);
        if (reset) begin
            m_ptr  = 0;
            m_we   = 1'b0;
            m_nd   = 1'b0;
            m_bank = '0;
            m_addr = '0;
            m_data = '0;
            m_strb = '0;
        end else begin
            if (g >= 0) m_ptr = (g + 1) % N;
            m_we = we;
            m_nd = nd;
            if (we) begin
                m_bank = b;
                m_addr = a;
                m_data = d;
                m_strb = s;
            end
        end

        @(negedge clk);
        if (wenable) dut_wr_cnt++;
        check_eq("wenable",     64'(wenable),     64'(m_we));
        check_eq("null_drop",   64'(null_drop),   64'(m_nd));
        check_eq("wr_bank_sel", 64'(wr_bank_sel), 64'(m_bank));
        check_eq("waddr",       64'(waddr),       64'(m_addr));
        check_eq("wdata",       wdata,            m_data);
        check_eq("wstrb",       64'(wstrb),       64'(m_strb));
    endtask

    initial begin
        reset     = 1'b1;
        hold      = 1'b0;
        req_valid = '0;
        req_bank  = '0;
        req_addr  = '0;
        req_data  = '0;
        req_strb  = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;

        // Reset with everything valid: no handshake, clean write port
        set_port(0, 1'b1, 4'd3, 7'd10, 64'hAAAA_BBBB_CCCC_DDDD, 2'b11);
        set_port(1, 1'b1, 4'd5, 7'd20, 64'h1111_2222_3333_4444, 2'b11);
        set_port(2, 1'b1, 4'd7, 7'd31, 64'h5555_6666_7777_8888, 2'b10);
        @(negedge clk);
        step();
        step();
        check_eq("rst_wenable", 64'(wenable), 64'd0);

        // All valid after reset: grants 0,1,2 back to back
        reset = 1'b0;
        step();
        check_eq("p0_wenable", 64'(wenable),     64'd1);
        check_eq("p0_bank",    64'(wr_bank_sel), 64'd3);
        check_eq("p0_waddr",   64'(waddr),       64'd10);
        check_eq("p0_wstrb",   64'(wstrb),       64'd3);
        check_eq("p0_wdata",   wdata,            64'hAAAA_BBBB_CCCC_DDDD);
        step();
        step();
        req_valid = '0;
        step();

        // Odd address: strobe and data folded to the low word
        set_port(1, 1'b1, 4'd9, 7'd7, 64'h1234_5678_9ABC_DEF0, 2'b11);
        step();
        req_valid = '0;
        check_eq("odd_wstrb", 64'(wstrb), 64'd1);
        check_eq("odd_wdata", wdata,      64'h0000_0000_9ABC_DEF0);

        // NULL register and its even partner
        set_port(2, 1'b1, 4'd1, 7'd125, 64'hDEAD_BEEF_DEAD_BEEF, 2'b11);
        step();
        req_valid = '0;
        check_eq("null_we", 64'(wenable),   64'd0);
        check_eq("null_nd", 64'(null_drop), 64'd1);
        set_port(0, 1'b1, 4'd2, 7'd124, 64'hFEED_FACE_0BAD_CAFE, 2'b11);
        step();
        req_valid = '0;
        check_eq("pair_we",    64'(wenable),   64'd1);
        check_eq("pair_wstrb", 64'(wstrb),     64'd1);
        check_eq("pair_nd",    64'(null_drop), 64'd1);

        // Empty strobe: consumed silently
        set_port(0, 1'b1, 4'd4, 7'd40, 64'h0123_4567_89AB_CDEF, 2'b00);
        step();
        req_valid = '0;
        check_eq("zstrb_we", 64'(wenable),   64'd0);
        check_eq("zstrb_nd", 64'(null_drop), 64'd0);

        // Hold with all valid for 5 cycles, then resume at the saved pointer
        set_port(0, 1'b1, 4'd3, 7'd10, 64'hAAAA_BBBB_CCCC_DDDD, 2'b11);
        set_port(1, 1'b1, 4'd5, 7'd20, 64'h1111_2222_3333_4444, 2'b01);
        set_port(2, 1'b1, 4'd7, 7'd30, 64'h5555_6666_7777_8888, 2'b10);
        step();
        hold = 1'b1;
        repeat (5) step();
        hold = 1'b0;
        repeat (3) step();

        // Reset the cycle after a grant: stage is dropped, port 0 wins next
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("rst2_wenable", 64'(wenable), 64'd0);
        step();
        check_eq("rst2_bank", 64'(wr_bank_sel), 64'd3);

        // Random traffic
        dut_wr_cnt = 0;
        exp_wr_cnt = 0;
        max_wait   = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int p = 0; p < N; p++) begin
                logic [6:0] ra;
                case ($urandom_range(0, 3))
                    0:       ra = 7'd124;
                    1:       ra = 7'd125;
                    default: ra = 7'($urandom);
                endcase
                set_port(p, 1'($urandom_range(0, 9) < 7), 4'($urandom), ra,
                         {32'($urandom), 32'($urandom)}, 2'($urandom));
            end
            hold = ($urandom_range(0, 9) == 0);
            step();
        end
        hold      = 1'b0;
        req_valid = '0;
        step();

        check_eq("max_wait_ok", 64'(max_wait <= N - 1), 64'd1);
        check_eq("write_count", 64'(dut_wr_cnt),       64'(exp_wr_cnt));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
